// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared constants for the ALU control unit and its RV32M multiply/divide unit.
// Optional build macro: ALU_CTRL_MDU_FAST_MUL_EN (native multiply in the FIX cycle).
package alu_ctrl_mdu_pkg;

  // Base ALU select codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // Main control unit ALUop encodings
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RI   = 2'b10;
  localparam logic [1:0] ALUOP_PASS = 2'b11;

  // M-extension func3 codes
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [2:0] {
    MDU_IDLE = 3'd0,
    MDU_MUL  = 3'd1,
    MDU_DIV  = 3'd2,
    MDU_FIX  = 3'd3,
    MDU_DONE = 3'd4
  } mdu_state_e;

  // Operand signedness for an M-op: {op_a signed, op_b signed}
  function automatic logic [1:0] md_signed_ops(input logic [2:0] f3);
    case (f3)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: return 2'b11;
      MD_MULHSU:                       return 2'b10;
      default:                         return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_mdu_iter_core.sv
// mdu_iter_core: operand conditioning, iterative shift-add / restoring-divide
// datapath, iteration counter and final sign fix for the M-extension.
// Optional build macro: ALU_CTRL_MDU_FAST_MUL_EN removes the shift-add path and
// computes products with the native multiply operator instead.
module mdu_iter_core
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            special,
  output logic            last,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        sgn;
  logic              neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]   a_abs, b_abs, special_val;

  logic [2:0]        op_q, op_d;
  logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, spec_q, spec_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d, dvs_q, dvs_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next, acc_step, prod;
  logic [XLEN-1:0]   quot, rem;
`ifdef ALU_CTRL_MDU_FAST_MUL_EN
  logic [XLEN-1:0]   a_raw_q, a_raw_d, b_raw_q, b_raw_d;
  logic [1:0]        sgn_q, sgn_d;
`else
  logic [XLEN:0]     mul_sum;
`endif

  // Magnitudes, signs and divide corner cases of the operands being issued
  always_comb begin
    sgn         = md_signed_ops(func3);
    neg_a       = sgn[1] & op_a[XLEN-1];
    neg_b       = sgn[0] & op_b[XLEN-1];
    a_abs       = neg_a ? -op_a : op_a;
    b_abs       = neg_b ? -op_b : op_b;
    div_zero    = func3[2] & (op_b == '0);
    div_ovf     = func3[2] & ~func3[0] & (op_a == MOST_NEG) & (&op_b);
    special     = div_zero | div_ovf;
    if (div_zero) special_val = func3[1] ? op_a : '1;
    else          special_val = func3[1] ? '0 : op_a;
  end

  // One iteration: restoring subtract (divide) or shift-add (multiply)
  always_comb begin
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, dvs_q};
    div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_step = div_next;
`ifndef ALU_CTRL_MDU_FAST_MUL_EN
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, dvs_q};
    if (!op_q[2])
      acc_step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
`endif
  end

  // Capture operands at start, then advance one iteration per step
  always_comb begin
    op_d       = op_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    dvs_d      = dvs_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
`ifdef ALU_CTRL_MDU_FAST_MUL_EN
    a_raw_d    = a_raw_q;
    b_raw_d    = b_raw_q;
    sgn_d      = sgn_q;
`endif
    if (load) begin
      op_d       = func3;
      neg_res_d  = neg_a ^ neg_b;
      neg_rem_d  = neg_a;
      spec_d     = special;
      spec_val_d = special_val;
      dvs_d      = b_abs;
      acc_d      = {{XLEN{1'b0}}, a_abs};
      cnt_d      = CNT_W'(XLEN);
`ifdef ALU_CTRL_MDU_FAST_MUL_EN
      a_raw_d    = op_a;
      b_raw_d    = op_b;
      sgn_d      = sgn;
`endif
    end else if (step) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      dvs_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
`ifdef ALU_CTRL_MDU_FAST_MUL_EN
      a_raw_q    <= '0;
      b_raw_q    <= '0;
      sgn_q      <= '0;
`endif
    end else begin
      op_q       <= op_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      dvs_q      <= dvs_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
`ifdef ALU_CTRL_MDU_FAST_MUL_EN
      a_raw_q    <= a_raw_d;
      b_raw_q    <= b_raw_d;
      sgn_q      <= sgn_d;
`endif
    end
  end

  assign last = (cnt_q == CNT_W'(1));

  // Sign correction and half / quotient-remainder selection
  always_comb begin
`ifdef ALU_CTRL_MDU_FAST_MUL_EN
    prod = (sgn_q[1] ? {{XLEN{a_raw_q[XLEN-1]}}, a_raw_q} : {{XLEN{1'b0}}, a_raw_q}) *
           (sgn_q[0] ? {{XLEN{b_raw_q[XLEN-1]}}, b_raw_q} : {{XLEN{1'b0}}, b_raw_q});
`else
    prod = neg_res_q ? -acc_q : acc_q;
`endif
    quot = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (spec_q)        result = spec_val_q;
    else if (!op_q[2]) result = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else               result = op_q[1] ? rem : quot;
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: ALU select decode for rv32i plus the RV32M multiply/divide
// sequencer and its stall/done handshake toward the datapath.
// Optional build macro: ALU_CTRL_MDU_FAST_MUL_EN (2-cycle multiplies).
module alu_ctrl_mdu
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ALUop,
  input  logic [2:0]      func3,
  input  logic            func7_5,
  input  logic            func7_0,
  input  logic            is_rtype,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic [3:0]      ALU_sel,
  output logic            md_req,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);
  mdu_state_e      state_q, state_d;
  logic            done_prev_q, done_prev_d;
  logic [XLEN-1:0] md_result_q, md_result_d;
  logic            core_load, core_step, result_we, core_special, core_last;
  logic [XLEN-1:0] core_result;

  // Instruction decode to ALU select code and M-op request
  always_comb begin
    ALU_sel = ALU_ADD;
    md_req  = (ALUop == ALUOP_RI) & is_rtype & func7_0;
    case (ALUop)
      ALUOP_ADD:  ALU_sel = ALU_ADD;
      ALUOP_SUB:  ALU_sel = ALU_SUB;
      ALUOP_PASS: ALU_sel = ALU_PASS;
      default: begin
        if (!md_req) begin
          case (func3)
            3'd0:    ALU_sel = (is_rtype & func7_5) ? ALU_SUB : ALU_ADD;
            3'd1:    ALU_sel = ALU_SLL;
            3'd2:    ALU_sel = ALU_SLT;
            3'd3:    ALU_sel = ALU_SLTU;
            3'd4:    ALU_sel = ALU_XOR;
            3'd5:    ALU_sel = func7_5 ? ALU_SRA : ALU_SRL;
            3'd6:    ALU_sel = ALU_OR;
            default: ALU_sel = ALU_AND;
          endcase
        end
      end
    endcase
  end

  // Sequencer state, done history and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MDU_IDLE;
      done_prev_q <= 1'b0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= done_prev_d;
      md_result_q <= md_result_d;
    end
  end

  // Next state; flush always returns to IDLE and beats a start
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (md_req && !done_prev_q) begin
            if (core_special)  state_d = MDU_FIX;
            else if (func3[2]) state_d = MDU_DIV;
`ifdef ALU_CTRL_MDU_FAST_MUL_EN
            else               state_d = MDU_FIX;
`else
            else               state_d = MDU_MUL;
`endif
          end
        end
`ifndef ALU_CTRL_MDU_FAST_MUL_EN
        MDU_MUL:  if (core_last) state_d = MDU_FIX;
`endif
        MDU_DIV:  if (core_last) state_d = MDU_FIX;
        MDU_FIX:  state_d = MDU_DONE;
        default:  state_d = MDU_IDLE;
      endcase
    end
  end

  // Handshake outputs and datapath controls per state
  always_comb begin
    md_stall  = 1'b0;
    md_done   = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    result_we = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        md_stall  = md_req;
        core_load = md_req & ~done_prev_q & ~flush;
      end
`ifndef ALU_CTRL_MDU_FAST_MUL_EN
      MDU_MUL: begin
        md_stall  = 1'b1;
        core_step = 1'b1;
      end
`endif
      MDU_DIV: begin
        md_stall  = 1'b1;
        core_step = 1'b1;
      end
      MDU_FIX: begin
        md_stall  = 1'b1;
        result_we = ~flush;
      end
      MDU_DONE: md_done = 1'b1;
      default: ;
    endcase
    done_prev_d = (state_q == MDU_DONE);
    md_result_d = result_we ? core_result : md_result_q;
  end

  assign md_result = md_result_q;

  mdu_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (core_load),
    .step    (core_step),
    .func3   (func3),
    .op_a    (op_a),
    .op_b    (op_b),
    .special (core_special),
    .last    (core_last),
    .result  (core_result)
  );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed self-checking bench for alu_ctrl_mdu at XLEN=32.
// Honours ALU_CTRL_MDU_FAST_MUL_EN for the expected multiply latency.
module tb_alu_ctrl_mdu;
  import alu_ctrl_mdu_pkg::*;

`ifdef ALU_CTRL_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ALUop;
  logic [2:0]  func3;
  logic        func7_5, func7_0, is_rtype, flush;
  logic [31:0] op_a, op_b;
  logic [3:0]  ALU_sel;
  logic        md_req, md_stall, md_done;
  logic [31:0] md_result;

  int errors = 0;
  int checks = 0;

  alu_ctrl_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ALUop(ALUop), .func3(func3), .func7_5(func7_5),
    .func7_0(func7_0), .is_rtype(is_rtype), .op_a(op_a), .op_b(op_b), .flush(flush),
    .ALU_sel(ALU_sel), .md_req(md_req), .md_stall(md_stall), .md_done(md_done),
    .md_result(md_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_sel(input logic [1:0] aop, input logic [2:0] f3,
                                         input logic f75, input logic f70, input logic rt);
    logic [3:0] s;
    case (aop)
      2'b00: s = ALU_ADD;
      2'b01: s = ALU_SUB;
      2'b11: s = ALU_PASS;
      default: begin
        if (rt && f70) s = ALU_ADD;
        else begin
          case (f3)
            3'd0: s = (rt && f75) ? ALU_SUB : ALU_ADD;
            3'd1: s = ALU_SLL;
            3'd2: s = ALU_SLT;
            3'd3: s = ALU_SLTU;
            3'd4: s = ALU_XOR;
            3'd5: s = f75 ? ALU_SRA : ALU_SRL;
            3'd6: s = ALU_OR;
            default: s = ALU_AND;
          endcase
        end
      end
    endcase
    return s;
  endfunction

  task automatic idle_inputs();
    ALUop = 2'b00; func3 = 3'd0; func7_5 = 1'b0; func7_0 = 1'b0; is_rtype = 1'b0;
    op_a = '0; op_b = '0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ALUop = 2'b10; is_rtype = 1'b1; func7_0 = 1'b1; func7_5 = 1'b0;
    func3 = f3; op_a = a; op_b = b;
  endtask

  // Entered at posedge+1 with the unit idle; issues one M-op and waits for md_done
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    issue(f3, a, b);
    #1;
    check({tag, " stall at start"}, {31'd0, md_stall}, 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!md_done && lat < 100);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, md_result, exp_res);
    $display("op %-8s a=%h b=%h result=%h latency=%0d", tag, a, b, md_result, lat);
    idle_inputs();
    @(posedge clk); #1;
    check({tag, " done pulse"}, {31'd0, md_done}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int done_cnt;
    int lat;
    logic [31:0] prev;
    logic [7:0] v;

    rst = 1'b1; flush = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", {31'd0, md_stall}, 32'd0);
    check("reset done", {31'd0, md_done}, 32'd0);
    check("reset result", md_result, 32'd0);
    check("reset sel", {28'd0, ALU_sel}, 32'd0);
    rst = 1'b0;

    // Decode sweep; flush held so no M-op can start meanwhile
    flush = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      ALUop = v[7:6]; func3 = v[5:3]; func7_5 = v[2]; func7_0 = v[1]; is_rtype = v[0];
      #1;
      check("decode sel", {28'd0, ALU_sel}, {28'd0, exp_sel(v[7:6], v[5:3], v[2], v[1], v[0])});
      check("decode md_req", {31'd0, md_req}, {31'd0, (v[7:6] == 2'b10) && v[1] && v[0]});
    end
    $display("decode sweep: 256 combinations, errors so far=%0d", errors);
    flush = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;

    run_op("MUL",    MD_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MUL_LAT);
    run_op("MULH",   MD_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
    run_op("MULHU",  MD_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, MUL_LAT);
    run_op("MULHSU", MD_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT);
    run_op("MUL2",   MD_MUL,    32'h12345678, 32'h00000009, 32'hA3D70A38, MUL_LAT);
    run_op("MULHmin",MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_op("MULHSU2",MD_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MUL_LAT);
    run_op("DIV",    MD_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT);
    run_op("REM",    MD_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT);
    run_op("DIVU",   MD_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, DIV_LAT);
    run_op("REMU",   MD_REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001, DIV_LAT);
    run_op("DIV2",   MD_DIV,    32'd100,      32'd7,        32'd14,       DIV_LAT);
    run_op("REM2",   MD_REM,    32'd100,      32'd7,        32'd2,        DIV_LAT);
    run_op("DIVU0",  MD_DIVU,   32'h00001234, 32'h00000000, 32'hFFFFFFFF, 2);
    run_op("REM0",   MD_REM,    32'd5,        32'h00000000, 32'd5,        2);
    run_op("DIVOVF", MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op("REMOVF", MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);

    // Flush 10 cycles into a divide
    prev = md_result;
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    check("flush stall before", {31'd0, md_stall}, 32'd1);
    flush = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush stall after", {31'd0, md_stall}, 32'd0);
    check("flush result kept", md_result, prev);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (md_done) done_cnt++;
    end
    check("flush no done", done_cnt, 32'd0);
    $display("op flush    after 10 cycles, result=%h done_pulses=%0d", md_result, done_cnt);
    run_op("DIVre",  MD_DIV,    32'd100,      32'd7,        32'd14,       DIV_LAT);

    // Flush coincident with a start
    issue(MD_MUL, 32'd3, 32'd4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle_inputs();
    #1;
    check("flush at start stall", {31'd0, md_stall}, 32'd0);
    check("flush at start result", md_result, 32'd14);
    $display("op flush    coincident with start, stall=%0b", md_stall);
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    issue(MD_MUL, 32'h12345678, 32'd9);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    check("rst mid sel", {28'd0, ALU_sel}, 32'd0);
    check("rst mid req", {31'd0, md_req}, 32'd0);
    check("rst mid stall", {31'd0, md_stall}, 32'd0);
    check("rst mid done", {31'd0, md_done}, 32'd0);
    check("rst mid result", md_result, 32'd0);
    $display("op reset    mid-multiply, result=%h stall=%0b", md_result, md_stall);
    rst = 1'b0;
    @(posedge clk); #1;

    // Request held past md_done must not restart
    issue(MD_MUL, 32'd6, 32'd7);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!md_done && lat < 100);
    check("held latency", lat, MUL_LAT);
    check("held result", md_result, 32'd42);
    @(posedge clk); #1;
    check("held done pulse", {31'd0, md_done}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("held no restart", {31'd0, md_stall}, 32'd0);
    @(posedge clk); #1;
    check("held still idle", {31'd0, md_stall}, 32'd0);
    $display("op held     result=%h latency=%0d restart_stall=%0b", md_result, lat, md_stall);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
